matrix_uart_printer: RTL and testbench
======================================

// Module: matrix_uart_printer
// PURPOSE
//  Transmit-side counterpart of the UART matrix input path. On a start pulse it reads an m x n
//  matrix (row-major, from base_addr) out of matrix storage and renders it as decimal ASCII.
//  Elements in a row are separated by one space; each row ends with CR LF. Bytes go out on
//  uart_tx through an internal 8N1 transmitter. The top-level FSM drives it to display results.
// PARAMETERS
//  CLK_FREQ    100_000_000  clock frequency, Hz
//  BAUD_RATE   115200       UART bit rate; bit period = CLK_FREQ/BAUD_RATE clocks (868)
//  DATA_W      32           element width, signed two's complement
//  ADDR_W      8            storage address width
//  MAX_DIGITS  10           decimal digit buffer depth (covers |-2^31|)
// PORTS
//  clk        in   1       clock
//  rst        in   1       async active-high reset
//  start      in   1       1-cycle request; sampled only when busy=0
//  dim_m      in   3       rows, legal 1..5, sampled at start
//  dim_n      in   3       cols, legal 1..5, sampled at start
//  base_addr  in   ADDR_W  matrix base address, sampled at start
//  rd_addr    out  ADDR_W  storage read address (base + index)
//  rd_en      out  1       read strobe; rd_data valid exactly 1 cycle later
//  rd_data    in   DATA_W  storage read data
//  uart_tx    out  1       serial line, idle high
//  busy       out  1       high from accepted start to done
//  done       out  1       1-cycle pulse at end of job
//  err        out  1       high with done when dims illegal; cleared by next accepted start
// BEHAVIOUR
//  Interface: one clock (clk); reset is asynchronous and active-high (rst).
//  Reset values: uart_tx=1, rd_addr=0, rd_en=0, busy=0, done=0, err=0; FSM -> IDLE, counters 0.
//  Reset mid-transmission aborts the frame immediately (line high next edge, no completion).
//  FSM: IDLE -> CHECK -> FETCH -> WAIT_RD -> CONVERT -> SEND_SIGN -> SEND_DIGIT -> SEND_SEP
//       -> (next element: FETCH | row end: SEND_CR -> SEND_LF -> FETCH | last: DONE) -> IDLE.
//  IDLE: start && !busy latches dims/base, clears err, busy=1 next cycle. start while busy ignored.
//  CHECK: dim_m or dim_n outside 1..5 -> DONE with err=1, zero bytes sent.
//  FETCH: rd_addr = base_addr + row*dim_n + col (ADDR_W wrap-around), rd_en=1 one cycle.
//  WAIT_RD: capture rd_data into element register.
//  CONVERT: magnitude = |value| (-2^31 handled as unsigned 2^31); one digit per cycle via
//   /10 and %10 into buffer LSB-first; stop when quotient=0; value 0 yields one digit '0'.
//   Digit count <= MAX_DIGITS; conversion takes digits cycles.
//  SEND_SIGN: '-' (8'd45) only if negative; then digits MSB-first as 8'd48+d.
//  SEND_SEP: ' ' (8'd32) after every element except last of a row; row end sends 8'd13, 8'd10.
//   Last row also ends with CR LF before DONE.
//  Byte handoff: FSM issues tx_start only when tx_busy=0; advances on the tx_start cycle; no byte
//   is ever dropped or duplicated. Back-to-back frames: next start bit begins the cycle after
//   the previous stop bit completes.
//  Frame: start bit 0, 8 data bits LSB-first, stop bit 1, each exactly bit-period clocks.
//  DONE: done=1 one cycle, busy falls same cycle; return to IDLE.
//  Total bytes for all-single-digit matrix m x n: m*(2n-1) + 2m.
// STRUCTURE
//  Shared package: ASCII constants (ASC_0, ASC_SPACE, ASC_CR, ASC_LF, ASC_MINUS), dim limits
//  (DIM_MIN=1, DIM_MAX=5), FSM state encoding.
//  Sub-module: uart_tx (CLK_FREQ, BAUD_RATE; clk, rst, tx_start, tx_data[7:0], tx, tx_busy).
//  Digit converter and sequencing FSM remain in this module.
// TESTING
//  1) m=1,n=1, mem[base]=7 -> bytes "7",CR,LF; done 1 pulse; err=0; 3 frames of 868-clk bits.
//  2) m=2,n=3, base=10, mem[10..15]=1..6 -> "1 2 3\r\n4 5 6\r\n" (14 bytes), rd_addr 10..15.
//  3) m=1,n=3, values 0, -45, 2147483647 -> "0 -45 2147483647\r\n"; also -2^31 -> "-2147483648".
//  4) start with dim_m=0 or dim_n=6 -> done+err within 3 cycles, uart_tx stays 1, no rd_en.
//  5) second start pulse while busy -> ignored, output identical to single job; base=250,
//     m=n=3 -> rd_addr wraps 250..255,0..2.
//  6) assert rst mid-byte -> uart_tx=1, busy=0 next edge; new start afterwards prints cleanly.

Source files
------------

// File: rtl/matrix_uart_printer_pkg.sv
// Shared constants and state encoding for the matrix-to-ASCII UART printer.
package matrix_uart_printer_pkg;

    localparam logic [7:0] ASC_0     = 8'd48;
    localparam logic [7:0] ASC_SPACE = 8'd32;
    localparam logic [7:0] ASC_CR    = 8'd13;
    localparam logic [7:0] ASC_LF    = 8'd10;
    localparam logic [7:0] ASC_MINUS = 8'd45;

    localparam logic [2:0] DIM_MIN = 3'd1;
    localparam logic [2:0] DIM_MAX = 3'd5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FETCH,
        ST_WAIT_RD,
        ST_CONVERT,
        ST_SEND_SIGN,
        ST_SEND_DIGIT,
        ST_SEND_SEP,
        ST_SEND_CR,
        ST_SEND_LF,
        ST_DONE
    } state_t;

    function automatic logic dim_ok(input logic [2:0] d);
        return (d >= DIM_MIN) && (d <= DIM_MAX);
    endfunction

endpackage

// File: rtl/matrix_uart_printer_uart_tx.sv
// 8N1 serial transmitter; a new frame may be accepted on the final cycle of the
// previous stop bit so back-to-back bytes have no idle gap.
module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy
);

    localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       bit_reg;
    logic [8:0]       shift_reg;
    logic             busy_reg;
    logic             tx_reg;
    logic             frame_end;

    assign frame_end = busy_reg && (cnt_reg == CNT_LAST) && (bit_reg == 4'd9);
    assign tx_busy   = busy_reg && !frame_end;
    assign tx        = tx_reg;

    // bit_reg 0 is the start bit, 1..8 data bits, 9 the stop bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            bit_reg   <= 4'd0;
            shift_reg <= '0;
            busy_reg  <= 1'b0;
            tx_reg    <= 1'b1;
        end else if (tx_start && !tx_busy) begin
            cnt_reg   <= '0;
            bit_reg   <= 4'd0;
            shift_reg <= {1'b1, tx_data};
            busy_reg  <= 1'b1;
            tx_reg    <= 1'b0;
        end else if (busy_reg) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_reg <= '0;
                if (bit_reg == 4'd9) begin
                    busy_reg <= 1'b0;
                end else begin
                    tx_reg    <= shift_reg[0];
                    shift_reg <= {1'b1, shift_reg[8:1]};
                    bit_reg   <= bit_reg + 4'd1;
                end
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_uart_printer.sv
// Reads an m x n signed matrix from storage and prints it as decimal ASCII rows
// (space separated, CR LF terminated) over an 8N1 UART.
module matrix_uart_printer
    import matrix_uart_printer_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int MAX_DIGITS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        dim_m,
    input  logic [2:0]        dim_n,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              uart_tx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DIG_W = $clog2(MAX_DIGITS + 1);

    state_t            state_reg;
    logic [2:0]        m_reg, n_reg, row_reg, col_reg;
    logic [ADDR_W-1:0] base_reg, rd_addr_reg;
    logic              rd_en_reg, busy_reg, done_reg, err_reg, neg_reg;
    logic [DATA_W-1:0] mag_reg;
    logic [DIG_W-1:0]  ndig_reg, dig_idx_reg;
    logic [3:0]        digit_mem [MAX_DIGITS];

    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] mag_quot;
    logic [3:0]        mag_digit;
    logic              last_col, last_row;
    logic              tx_req, tx_start, tx_busy;
    logic [7:0]        tx_byte;

    assign addr_next = base_reg + ADDR_W'(row_reg) * ADDR_W'(n_reg) + ADDR_W'(col_reg);
    assign mag_quot  = mag_reg / DATA_W'(10);
    assign mag_digit = 4'(mag_reg % DATA_W'(10));
    assign last_col  = (col_reg == n_reg - 3'd1);
    assign last_row  = (row_reg == m_reg - 3'd1);

    always_comb begin
        tx_req  = 1'b0;
        tx_byte = ASC_0;
        case (state_reg)
            ST_SEND_SIGN:  begin tx_req = neg_reg;   tx_byte = ASC_MINUS; end
            ST_SEND_DIGIT: begin tx_req = 1'b1;      tx_byte = ASC_0 + {4'd0, digit_mem[dig_idx_reg]}; end
            ST_SEND_SEP:   begin tx_req = !last_col; tx_byte = ASC_SPACE; end
            ST_SEND_CR:    begin tx_req = 1'b1;      tx_byte = ASC_CR; end
            ST_SEND_LF:    begin tx_req = 1'b1;      tx_byte = ASC_LF; end
            default:       begin tx_req = 1'b0;      tx_byte = ASC_0; end
        endcase
    end

    assign tx_start = tx_req && !tx_busy;

    // Digits are produced least-significant first and replayed from the top index down
    always_ff @(posedge clk) begin
        if (state_reg == ST_CONVERT) begin
            digit_mem[ndig_reg] <= mag_digit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            m_reg       <= 3'd0;
            n_reg       <= 3'd0;
            row_reg     <= 3'd0;
            col_reg     <= 3'd0;
            base_reg    <= '0;
            rd_addr_reg <= '0;
            rd_en_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            neg_reg     <= 1'b0;
            mag_reg     <= '0;
            ndig_reg    <= '0;
            dig_idx_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: if (start) begin
                    m_reg     <= dim_m;
                    n_reg     <= dim_n;
                    base_reg  <= base_addr;
                    err_reg   <= 1'b0;
                    busy_reg  <= 1'b1;
                    row_reg   <= 3'd0;
                    col_reg   <= 3'd0;
                    state_reg <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (dim_ok(m_reg) && dim_ok(n_reg)) begin
                        state_reg <= ST_FETCH;
                    end else begin
                        err_reg   <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_FETCH: begin
                    rd_addr_reg <= addr_next;
                    rd_en_reg   <= 1'b1;
                    state_reg   <= ST_WAIT_RD;
                end
                // First cycle here has the strobe out; data arrives on the second
                ST_WAIT_RD: begin
                    if (rd_en_reg) begin
                        rd_en_reg <= 1'b0;
                    end else begin
                        neg_reg   <= rd_data[DATA_W-1];
                        mag_reg   <= rd_data[DATA_W-1] ? (~rd_data + DATA_W'(1)) : rd_data;
                        ndig_reg  <= '0;
                        state_reg <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    mag_reg  <= mag_quot;
                    ndig_reg <= ndig_reg + DIG_W'(1);
                    if (mag_quot == '0) begin
                        dig_idx_reg <= ndig_reg;
                        state_reg   <= ST_SEND_SIGN;
                    end
                end
                ST_SEND_SIGN: if (!neg_reg || tx_start) state_reg <= ST_SEND_DIGIT;
                ST_SEND_DIGIT: if (tx_start) begin
                    if (dig_idx_reg == '0) state_reg <= ST_SEND_SEP;
                    else dig_idx_reg <= dig_idx_reg - DIG_W'(1);
                end
                ST_SEND_SEP: begin
                    if (last_col) begin
                        state_reg <= ST_SEND_CR;
                    end else if (tx_start) begin
                        col_reg   <= col_reg + 3'd1;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_SEND_CR: if (tx_start) state_reg <= ST_SEND_LF;
                ST_SEND_LF: if (tx_start) begin
                    col_reg <= 3'd0;
                    if (last_row) begin
                        state_reg <= ST_DONE;
                    end else begin
                        row_reg   <= row_reg + 3'd1;
                        state_reg <= ST_FETCH;
                    end
                end
                // Hold completion until the final frame has left the line
                ST_DONE: if (!tx_busy) begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rd_addr = rd_addr_reg;
    assign rd_en   = rd_en_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign err     = err_reg;

    uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_byte),
        .tx       (uart_tx),
        .tx_busy  (tx_busy)
    );

endmodule

// File: tb/tb_matrix_uart_printer.sv
// Directed bench: a fast-baud instance for most jobs, a default-rate instance for exact bit timing.
module tb_matrix_uart_printer;

    localparam int BP_A = 16;
    localparam int BP_B = 868;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [2:0]  dim_m = 3'd0, dim_n = 3'd0;
    logic [7:0]  base_addr = 8'd0;
    logic [7:0]  rd_addr_a, rd_addr_b;
    logic        rd_en_a, rd_en_b;
    logic [31:0] rd_data_a = 32'd0, rd_data_b = 32'd0;
    logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    matrix_uart_printer #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dim_m(dim_m), .dim_n(dim_n),
        .base_addr(base_addr), .rd_addr(rd_addr_a), .rd_en(rd_en_a), .rd_data(rd_data_a),
        .uart_tx(tx_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    matrix_uart_printer dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dim_m(dim_m), .dim_n(dim_n),
        .base_addr(base_addr), .rd_addr(rd_addr_b), .rd_en(rd_en_b), .rd_data(rd_data_b),
        .uart_tx(tx_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Storage model: one-cycle registered read
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= mem[rd_addr_a];
        if (rd_en_b) rd_data_b <= mem[rd_addr_b];
    end

    int rx_a[$], rx_b[$], addr_a[$], runs_b[$];
    int done_cnt_a = 0, done_cnt_b = 0, rd_cnt_a = 0, fall_cnt_a = 0, rst_epoch = 0;
    longint t_edge_b = 0;
    bit trk_b = 1'b0;

    always @(posedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (rd_en_a) begin
            rd_cnt_a++;
            addr_a.push_back(int'(rd_addr_a));
        end
    end

    always @(posedge rst) rst_epoch++;

    always begin : mon_a
        int ep;
        logic [7:0] b;
        logic sb, pb;
        @(negedge tx_a);
        fall_cnt_a++;
        ep = rst_epoch;
        repeat (BP_A / 2) @(posedge clk);
        sb = tx_a;
        for (int i = 0; i < 8; i++) begin
            repeat (BP_A) @(posedge clk);
            b[i] = tx_a;
        end
        repeat (BP_A) @(posedge clk);
        pb = tx_a;
        if (ep == rst_epoch) rx_a.push_back((sb == 1'b0 && pb == 1'b1) ? int'(b) : -1);
    end

    always begin : mon_b
        logic [7:0] b;
        logic sb, pb;
        @(negedge tx_b);
        repeat (BP_B / 2) @(posedge clk);
        sb = tx_b;
        for (int i = 0; i < 8; i++) begin
            repeat (BP_B) @(posedge clk);
            b[i] = tx_b;
        end
        repeat (BP_B) @(posedge clk);
        pb = tx_b;
        rx_b.push_back((sb == 1'b0 && pb == 1'b1) ? int'(b) : -1);
    end

    // Line run lengths on the full-rate instance, in clock cycles
    always @(posedge tx_b or negedge tx_b) begin
        if (trk_b) runs_b.push_back(int'(($time - t_edge_b) / 10));
        else if (tx_b == 1'b0) trk_b = 1'b1;
        t_edge_b = $time;
    end

    task automatic run_job(input bit sel, input int m, input int n, input int base,
                           input string exp, input string tag, input int dup_at);
        int dc0, limit, cyc, got, bp;
        bit seen;
        logic e;
        rx_a.delete();
        rx_b.delete();
        addr_a.delete();
        bp    = sel ? BP_B : BP_A;
        dc0   = sel ? done_cnt_b : done_cnt_a;
        limit = (exp.len() + 2) * 10 * bp + 100;
        seen  = 1'b0;
        cyc   = 0;
        e     = 1'b0;
        @(negedge clk);
        dim_m = 3'(m);
        dim_n = 3'(n);
        base_addr = 8'(base);
        if (sel) start_b = 1'b1;
        else start_a = 1'b1;
        while (!seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            start_b = 1'b0;
            start_a = (dup_at > 0 && cyc == dup_at);
            if (start_a) begin
                dim_m = 3'd1;
                dim_n = 3'd1;
                base_addr = 8'd0;
            end
            if (sel ? done_b : done_a) begin
                seen = 1'b1;
                e = sel ? err_b : err_a;
            end
        end
        start_a = 1'b0;
        chk({tag, " done seen"}, longint'(seen), 1);
        chk({tag, " err"}, longint'(e), 0);
        repeat (2 * bp) @(negedge clk);
        chk({tag, " busy after"}, longint'(sel ? busy_b : busy_a), 0);
        chk({tag, " done pulses"}, (sel ? done_cnt_b : done_cnt_a) - dc0, 1);
        chk({tag, " byte count"}, sel ? rx_b.size() : rx_a.size(), exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            if (sel) got = (i < rx_b.size()) ? rx_b[i] : -2;
            else     got = (i < rx_a.size()) ? rx_a[i] : -2;
            chk($sformatf("%s byte%0d", tag, i), got, longint'(exp[i]));
        end
        $display("job %s: m=%0d n=%0d base=%0d bytes=%0d cycles=%0d", tag, m, n, base,
                 sel ? rx_b.size() : rx_a.size(), cyc);
    endtask

    task automatic err_job(input int m, input int n, input string tag);
        int rd0, f0, dc0, cyc;
        bit seen;
        logic e;
        rd0 = rd_cnt_a;
        f0 = fall_cnt_a;
        dc0 = done_cnt_a;
        seen = 1'b0;
        cyc = 0;
        e = 1'b0;
        @(negedge clk);
        dim_m = 3'(m);
        dim_n = 3'(n);
        base_addr = 8'd0;
        start_a = 1'b1;
        while (!seen && cyc < 3) begin
            @(negedge clk);
            start_a = 1'b0;
            cyc++;
            if (done_a) begin
                seen = 1'b1;
                e = err_a;
            end
        end
        start_a = 1'b0;
        chk({tag, " done within 3"}, longint'(seen), 1);
        chk({tag, " err"}, longint'(e), 1);
        repeat (40) @(negedge clk);
        chk({tag, " rd_en count"}, rd_cnt_a - rd0, 0);
        chk({tag, " tx falls"}, fall_cnt_a - f0, 0);
        chk({tag, " tx idle"}, longint'(tx_a), 1);
        chk({tag, " done pulses"}, done_cnt_a - dc0, 1);
        chk({tag, " busy"}, longint'(busy_a), 0);
        $display("job %s: m=%0d n=%0d done after %0d cycles err=%0d", tag, m, n, cyc, e);
    endtask

    int exp_runs[17] = '{1, 3, 1, 2, 2, 1, 1, 1, 1, 2, 4, 1, 2, 1, 1, 1, 4};

    initial begin
        int got, dc0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = 32'd7; mem[1] = 32'd8; mem[2] = 32'd9;
        for (int i = 0; i < 6; i++) mem[10 + i] = 32'(i + 1);
        mem[20] = 32'd0;
        mem[21] = 32'hFFFF_FFD3;
        mem[22] = 32'h7FFF_FFFF;
        mem[30] = 32'h8000_0000;
        for (int i = 0; i < 6; i++) mem[250 + i] = 32'(i + 1);

        repeat (3) @(negedge clk);
        chk("reset uart_tx", longint'(tx_a), 1);
        chk("reset rd_addr", longint'(rd_addr_a), 0);
        chk("reset rd_en", longint'(rd_en_a), 0);
        chk("reset busy", longint'(busy_a), 0);
        chk("reset done", longint'(done_a), 0);
        chk("reset err", longint'(err_a), 0);
        chk("reset uart_tx full", longint'(tx_b), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full-rate job: check decoded bytes and every line run length
        run_job(1'b1, 1, 1, 0, "7\015\012", "t1", 0);
        chk("t1 run count", runs_b.size(), 17);
        for (int i = 0; i < 17; i++) begin
            got = (i < runs_b.size()) ? runs_b[i] : -1;
            chk($sformatf("t1 run%0d cycles", i), got, exp_runs[i] * BP_B);
        end

        run_job(1'b0, 2, 3, 10, "1 2 3\015\0124 5 6\015\012", "t2", 0);
        chk("t2 read count", addr_a.size(), 6);
        for (int i = 0; i < 6; i++) begin
            got = (i < addr_a.size()) ? addr_a[i] : -1;
            chk($sformatf("t2 rd_addr%0d", i), got, 10 + i);
        end

        run_job(1'b0, 1, 3, 20, "0 -45 2147483647\015\012", "t3 mixed", 0);
        run_job(1'b0, 1, 1, 30, "-2147483648\015\012", "t3 min", 0);

        err_job(0, 2, "t4 m0");
        err_job(2, 6, "t4 n6");

        run_job(1'b0, 3, 3, 250, "1 2 3\015\0124 5 6\015\0127 8 9\015\012", "t5", 300);
        chk("t5 read count", addr_a.size(), 9);
        for (int i = 0; i < 9; i++) begin
            got = (i < addr_a.size()) ? addr_a[i] : -1;
            chk($sformatf("t5 rd_addr%0d", i), got, (250 + i) % 256);
        end

        // Reset in the middle of the first frame
        dc0 = done_cnt_a;
        @(negedge clk);
        dim_m = 3'd1;
        dim_n = 3'd2;
        base_addr = 8'd10;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (40) @(negedge clk);
        chk("t6 busy before reset", longint'(busy_a), 1);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6 uart_tx after reset", longint'(tx_a), 1);
        chk("t6 busy after reset", longint'(busy_a), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12 * BP_A) @(negedge clk);
        chk("t6 no done for aborted job", done_cnt_a - dc0, 0);
        run_job(1'b0, 1, 2, 10, "1 2\015\012", "t6 after reset", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
